// File: rtl/fpga_msg_tx.sv
// fpga_msg_tx: turns host commands into framed 32-bit words for the host-bound FIFO.
//   bus_clk   in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   cmd_empty in   command FIFO (FWFT) empty
//   cmd_data  in   head-of-FIFO command, opcode in [31:28]
//   cmd_rd_en out  registered one-cycle pop of the command FIFO
//   tx_full   in   host-bound FIFO full
//   tx_wr_en  out  combinational write strobe into host-bound FIFO
//   tx_data   out  word written when tx_wr_en=1
//   host_open in   host has the read device open
//   busy      out  state is not IDLE
//   seq       out  current frame sequence number
//   err       out  sticky unknown-opcode flag
module fpga_msg_tx #(
    parameter logic [7:0] HDR_TAG = 8'hA5,
    parameter logic [7:0] TRL_TAG = 8'h5A
) (
    input  logic        bus_clk,
    input  logic        reset,
    input  logic        cmd_empty,
    input  logic [31:0] cmd_data,
    output logic        cmd_rd_en,
    input  logic        tx_full,
    output logic        tx_wr_en,
    output logic [31:0] tx_data,
    input  logic        host_open,
    output logic        busy,
    output logic [7:0]  seq,
    output logic        err
);

    localparam int unsigned LEN_W = 16;
    localparam int unsigned SEQ_W = 8;

    localparam logic [3:0] OP_START = 4'h1;
    localparam logic [3:0] OP_STOP  = 4'h2;
    localparam logic [3:0] OP_PING  = 4'h3;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        TRAILER,
        PING
    } state_t;

    state_t             state, state_d;
    logic               rd_en_d;
    logic [SEQ_W-1:0]   seq_d;
    logic               err_d;
    logic               aborted, aborted_d;
    logic [LEN_W-1:0]   csum, csum_d;
    logic [LEN_W-1:0]   index, index_d;
    logic [LEN_W-1:0]   len, len_d;
    logic [LEN_W-1:0]   echo, echo_d;

    logic               head_valid;
    logic [3:0]         opcode;
    logic               can_write;
    logic [31:0]        pay_word;
    logic               unused_cmd_bits;

    // A command is only visible once the previous pop has taken effect
    assign head_valid      = !cmd_empty && !cmd_rd_en;
    assign opcode          = cmd_data[31:28];
    assign can_write       = !tx_full && host_open;
    assign pay_word        = {seq, 8'h00, index};
    // Reserved command bits, intentionally ignored
    assign unused_cmd_bits = ^cmd_data[27:16];
    assign busy            = (state != IDLE);

    // State and datapath registers
    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd_rd_en <= 1'b0;
            seq       <= '0;
            err       <= 1'b0;
            aborted   <= 1'b0;
            csum      <= '0;
            index     <= '0;
            len       <= '0;
            echo      <= '0;
        end else begin
            state     <= state_d;
            cmd_rd_en <= rd_en_d;
            seq       <= seq_d;
            err       <= err_d;
            aborted   <= aborted_d;
            csum      <= csum_d;
            index     <= index_d;
            len       <= len_d;
            echo      <= echo_d;
        end
    end

    // Next-state, write strobe and outgoing word
    always_comb begin
        state_d   = state;
        rd_en_d   = 1'b0;
        seq_d     = seq;
        err_d     = err;
        aborted_d = aborted;
        csum_d    = csum;
        index_d   = index;
        len_d     = len;
        echo_d    = echo;
        tx_wr_en  = 1'b0;
        tx_data   = '0;

        case (state)
            IDLE: begin
                if (head_valid) begin
                    rd_en_d = 1'b1;
                    case (opcode)
                        OP_START: begin
                            len_d   = cmd_data[15:0];
                            state_d = HDR;
                        end
                        OP_PING: begin
                            echo_d  = cmd_data[15:0];
                            state_d = PING;
                        end
                        OP_STOP: ;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            HDR: begin
                tx_data = {HDR_TAG, seq, len};
                if (!host_open) begin
                    state_d = IDLE;
                end else if (can_write) begin
                    tx_wr_en  = 1'b1;
                    csum_d    = '0;
                    index_d   = '0;
                    aborted_d = 1'b0;
                    state_d   = (len == '0) ? TRAILER : PAYLOAD;
                end
            end
            PAYLOAD: begin
                tx_data = pay_word;
                if (!host_open) begin
                    state_d = IDLE;
                end else if (head_valid && opcode == OP_STOP) begin
                    // STOP wins over a pending payload word, even under backpressure
                    rd_en_d   = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = TRAILER;
                end else if (can_write) begin
                    tx_wr_en = 1'b1;
                    csum_d   = csum ^ pay_word[31:16] ^ pay_word[15:0];
                    index_d  = index + LEN_W'(1);
                    if (index == len - LEN_W'(1)) begin
                        state_d = TRAILER;
                    end
                end
            end
            TRAILER: begin
                tx_data = {TRL_TAG, 7'b0, aborted, csum};
                if (!host_open) begin
                    state_d = IDLE;
                end else if (can_write) begin
                    tx_wr_en = 1'b1;
                    seq_d    = seq + SEQ_W'(1);
                    state_d  = IDLE;
                end
            end
            PING: begin
                tx_data = {4'h3, 12'h000, echo};
                if (!host_open) begin
                    state_d = IDLE;
                end else if (can_write) begin
                    tx_wr_en = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fpga_msg_tx.sv
// tb_fpga_msg_tx: directed bench for fpga_msg_tx with a FWFT command queue model
// and a capture queue of every word written to the host-bound FIFO.
module tb_fpga_msg_tx;

    logic        bus_clk = 1'b0;
    logic        reset;
    logic        cmd_empty;
    logic [31:0] cmd_data;
    logic        cmd_rd_en;
    logic        tx_full;
    logic        tx_wr_en;
    logic [31:0] tx_data;
    logic        host_open;
    logic        busy;
    logic [7:0]  seq;
    logic        err;

    logic [31:0] cmdq[$];
    logic [31:0] got[$];
    int          got_cyc[$];
    logic [31:0] exp_q[$];
    int          cyc_n;
    int          tests;
    int          fails;

    always #5 bus_clk = ~bus_clk;

    fpga_msg_tx dut (
        .bus_clk   (bus_clk),
        .reset     (reset),
        .cmd_empty (cmd_empty),
        .cmd_data  (cmd_data),
        .cmd_rd_en (cmd_rd_en),
        .tx_full   (tx_full),
        .tx_wr_en  (tx_wr_en),
        .tx_data   (tx_data),
        .host_open (host_open),
        .busy      (busy),
        .seq       (seq),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic refresh();
        cmd_empty = (cmdq.size() == 0);
        cmd_data  = cmd_empty ? 32'h0 : cmdq[0];
    endtask

    task automatic push(input logic [31:0] c);
        cmdq.push_back(c);
        refresh();
    endtask

    task automatic ex(input logic [31:0] w);
        exp_q.push_back(w);
    endtask

    // One clock: capture the write decided for the coming edge, then apply the FIFO pop
    task automatic cyc();
        logic pop;
        @(negedge bus_clk);
        if (tx_wr_en === 1'b1) begin
            got.push_back(tx_data);
            got_cyc.push_back(cyc_n + 1);
        end
        pop = cmd_rd_en;
        @(posedge bus_clk);
        #1;
        cyc_n++;
        if (pop === 1'b1 && cmdq.size() > 0) void'(cmdq.pop_front());
        refresh();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy !== 1'b0 || cmd_rd_en !== 1'b0 || cmdq.size() != 0) && n < budget) begin
            cyc();
            n++;
        end
        check(tag, {29'b0, busy, cmd_rd_en, ~cmd_empty}, 32'h0);
    endtask

    task automatic wait_got(input string tag, input int cnt, input int budget);
        int n;
        n = 0;
        while (got.size() < cnt && n < budget) begin
            cyc();
            n++;
        end
        check(tag, 32'(got.size()), 32'(cnt));
    endtask

    task automatic check_words(input string tag);
        check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i), got[i], exp_q[i]);
        end
        got.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int lat;
        tests     = 0;
        fails     = 0;
        cyc_n     = 0;
        reset     = 1'b1;
        tx_full   = 1'b0;
        host_open = 1'b1;
        refresh();
        cyc();
        cyc();

        // Reset state
        check("rst_wr_en", 32'(tx_wr_en), 32'h0);
        check("rst_rd_en", 32'(cmd_rd_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_seq", 32'(seq), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_data", tx_data, 32'h0);
        reset = 1'b0;
        cyc();

        // Basic frame, len 3, plus header latency
        k = cyc_n;
        push(32'h1000_0003);
        wait_idle("t1_idle", 50);
        lat = (got_cyc.size() > 0) ? got_cyc[0] - k : -1;
        check("t1_latency", 32'(lat), 32'd2);
        ex(32'hA500_0003); ex(32'h0000_0000); ex(32'h0000_0001); ex(32'h0000_0002);
        ex(32'h5A00_0003);
        check_words("t1");
        check("t1_seq", 32'(seq), 32'd1);

        // Empty frame
        push(32'h1000_0000);
        wait_idle("t2_idle", 50);
        ex(32'hA501_0000); ex(32'h5A00_0000);
        check_words("t2");
        check("t2_seq", 32'(seq), 32'd2);

        // Backpressure for 5 cycles inside a len-8 frame
        push(32'h1000_0008);
        repeat (4) cyc();
        check("t3_pre_full", 32'(got.size()), 32'd3);
        tx_full = 1'b1;
        repeat (5) cyc();
        check("t3_during_full", 32'(got.size()), 32'd3);
        tx_full = 1'b0;
        wait_idle("t3_idle", 50);
        ex(32'hA502_0008);
        for (int i = 0; i < 8; i++) ex(32'h0200_0000 | 32'(i));
        ex(32'h5A00_0000);
        check_words("t3");
        check("t3_seq", 32'(seq), 32'd3);

        // STOP after payload word 9 of a len-100 frame
        push(32'h1000_0064);
        wait_got("t4_ten", 11, 60);
        push(32'h2000_0000);
        wait_idle("t4_idle", 50);
        ex(32'hA503_0064);
        for (int i = 0; i < 10; i++) ex(32'h0300_0000 | 32'(i));
        ex(32'h5A01_0001);
        check_words("t4");
        check("t4_seq", 32'(seq), 32'd4);
        push(32'h1000_0001);
        wait_idle("t4b_idle", 50);
        ex(32'hA504_0001); ex(32'h0400_0000); ex(32'h5A00_0400);
        check_words("t4b");
        check("t4b_seq", 32'(seq), 32'd5);

        // PING, unknown opcode, STOP while idle
        push(32'h3000_BEEF);
        wait_idle("t5_ping_idle", 50);
        ex(32'h3000_BEEF);
        check_words("t5_ping");
        check("t5_ping_seq", 32'(seq), 32'd5);
        push(32'hF000_0000);
        wait_idle("t5_unk_idle", 50);
        check("t5_unk_words", 32'(got.size()), 32'd0);
        check("t5_err", 32'(err), 32'd1);
        push(32'h2000_0000);
        wait_idle("t5_stop_idle", 50);
        check("t5_stop_words", 32'(got.size()), 32'd0);
        check("t5_err_sticky", 32'(err), 32'd1);

        // host_open dropped mid-payload
        push(32'h1000_0005);
        wait_got("t6_start", 3, 20);
        host_open = 1'b0;
        cyc();
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_seq", 32'(seq), 32'd5);
        host_open = 1'b1;
        repeat (5) cyc();
        ex(32'hA505_0005); ex(32'h0500_0000); ex(32'h0500_0001);
        check_words("t6");

        // Reset mid-frame
        push(32'h1000_0005);
        wait_got("t7_start", 2, 20);
        reset = 1'b1;
        #1;
        check("t7_wr_en", 32'(tx_wr_en), 32'h0);
        check("t7_rd_en", 32'(cmd_rd_en), 32'h0);
        check("t7_busy", 32'(busy), 32'h0);
        check("t7_seq", 32'(seq), 32'h0);
        check("t7_err", 32'(err), 32'h0);
        check("t7_data", tx_data, 32'h0);
        cyc();
        cyc();
        reset = 1'b0;
        ex(32'hA505_0005); ex(32'h0500_0000);
        check_words("t7_partial");

        // Operation after reset restarts at seq 0
        push(32'h1000_0001);
        wait_idle("t8_idle", 50);
        ex(32'hA500_0001); ex(32'h0000_0000); ex(32'h5A00_0000);
        check_words("t8");
        check("t8_seq", 32'(seq), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
